// File: rtl/obi_atop_resolver.sv
// Converts OBI atomic requests into plain read / read-modify-write sequences on a manager port.
// Optional LR/SC support with a single reservation is compiled in by OBI_ATOP_RESOLVER_LRSC_EN.
module obi_atop_resolver #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // subordinate side
  input  logic                 sbr_req_i,
  output logic                 sbr_gnt_o,
  input  logic [AddrWidth-1:0] sbr_addr_i,
  input  logic                 sbr_we_i,
  input  logic [3:0]           sbr_be_i,
  input  logic [31:0]          sbr_wdata_i,
  input  logic [IdWidth-1:0]   sbr_aid_i,
  input  logic [5:0]           sbr_atop_i,
  output logic                 sbr_rvalid_o,
  output logic [31:0]          sbr_rdata_o,
  output logic [IdWidth-1:0]   sbr_rid_o,
  output logic                 sbr_err_o,
  // manager side
  output logic                 mgr_req_o,
  input  logic                 mgr_gnt_i,
  output logic [AddrWidth-1:0] mgr_addr_o,
  output logic                 mgr_we_o,
  output logic [3:0]           mgr_be_o,
  output logic [31:0]          mgr_wdata_o,
  input  logic                 mgr_rvalid_i,
  input  logic [31:0]          mgr_rdata_i,
  input  logic                 mgr_err_i
);

  localparam logic [5:0] ATOPNONE = 6'h00;
  localparam logic [5:0] AMOADD   = 6'h20;
  localparam logic [5:0] AMOSWAP  = 6'h21;
  localparam logic [5:0] ATOPLR   = 6'h22;
  localparam logic [5:0] ATOPSC   = 6'h23;
  localparam logic [5:0] AMOXOR   = 6'h24;
  localparam logic [5:0] AMOOR    = 6'h28;
  localparam logic [5:0] AMOAND   = 6'h2C;
  localparam logic [5:0] AMOMIN   = 6'h30;
  localparam logic [5:0] AMOMAX   = 6'h34;
  localparam logic [5:0] AMOMINU  = 6'h38;
  localparam logic [5:0] AMOMAXU  = 6'h3C;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP} state_e;
  typedef enum logic [1:0] {PATH_READ, PATH_WRITE, PATH_REJECT, PATH_SC_FAIL} path_e;

  state_e               state_q;
  logic                 sbr_gnt_q;
  logic                 sbr_rvalid_q;
  logic                 sbr_err_q;
  logic [31:0]          sbr_rdata_q;
  logic [IdWidth-1:0]   sbr_rid_q;
  logic                 mgr_req_q;
  logic                 mgr_we_q;
  logic [3:0]           mgr_be_q;
  logic [AddrWidth-1:0] mgr_addr_q;
  logic [31:0]          mgr_wdata_q;
  logic [5:0]           atop_q;
  logic [31:0]          operand_q;
  logic [31:0]          old_q;
  logic                 is_amo_q;

  path_e                path;
  logic                 is_amo;
  logic                 touches_mem_wr;

`ifdef OBI_ATOP_RESOLVER_LRSC_EN
  logic                 resv_valid_q;
  logic [AddrWidth-1:0] resv_addr_q;
`endif

  function automatic logic is_amo_code(input logic [5:0] op);
    case (op)
      AMOADD, AMOSWAP, AMOXOR, AMOOR, AMOAND,
      AMOMIN, AMOMAX, AMOMINU, AMOMAXU: is_amo_code = 1'b1;
      default:                          is_amo_code = 1'b0;
    endcase
  endfunction

  // o is the old memory value, w the operand supplied with the request.
  function automatic logic [31:0] amo_calc(input logic [5:0] op, input logic [31:0] o,
                                           input logic [31:0] w);
    case (op)
      AMOADD:  amo_calc = o + w;
      AMOXOR:  amo_calc = o ^ w;
      AMOAND:  amo_calc = o & w;
      AMOOR:   amo_calc = o | w;
      AMOMIN:  amo_calc = ($signed(o) < $signed(w)) ? o : w;
      AMOMAX:  amo_calc = ($signed(o) > $signed(w)) ? o : w;
      AMOMINU: amo_calc = (o < w) ? o : w;
      AMOMAXU: amo_calc = (o > w) ? o : w;
      default: amo_calc = w;
    endcase
  endfunction

  always_comb begin
    path           = PATH_REJECT;
    is_amo         = 1'b0;
    touches_mem_wr = 1'b0;
    if (sbr_atop_i == ATOPNONE) begin
      path           = sbr_we_i ? PATH_WRITE : PATH_READ;
      touches_mem_wr = sbr_we_i;
    end else if (is_amo_code(sbr_atop_i)) begin
      if (sbr_be_i == 4'hF) begin
        path           = PATH_READ;
        is_amo         = 1'b1;
        touches_mem_wr = 1'b1;
      end
    end
`ifdef OBI_ATOP_RESOLVER_LRSC_EN
    else if (sbr_atop_i == ATOPLR) begin
      path = PATH_READ;
    end else if (sbr_atop_i == ATOPSC) begin
      path = (resv_valid_q && (resv_addr_q == sbr_addr_i)) ? PATH_WRITE : PATH_SC_FAIL;
    end
`endif
  end

`ifdef OBI_ATOP_RESOLVER_LRSC_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else if (state_q == IDLE && sbr_req_i) begin
      if (sbr_atop_i == ATOPLR) begin
        resv_valid_q <= 1'b1;
        resv_addr_q  <= sbr_addr_i;
      end else if (sbr_atop_i == ATOPSC) begin
        resv_valid_q <= 1'b0;
      end else if (touches_mem_wr && (sbr_addr_i == resv_addr_q)) begin
        resv_valid_q <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sbr_gnt_q    <= 1'b1;
      sbr_rvalid_q <= 1'b0;
      sbr_err_q    <= 1'b0;
      sbr_rdata_q  <= '0;
      sbr_rid_q    <= '0;
      mgr_req_q    <= 1'b0;
      mgr_we_q     <= 1'b0;
      mgr_be_q     <= '0;
      mgr_addr_q   <= '0;
      mgr_wdata_q  <= '0;
      atop_q       <= '0;
      operand_q    <= '0;
      old_q        <= '0;
      is_amo_q     <= 1'b0;
    end else begin
      sbr_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sbr_req_i) begin
            sbr_gnt_q   <= 1'b0;
            sbr_rid_q   <= sbr_aid_i;
            sbr_err_q   <= 1'b0;
            sbr_rdata_q <= '0;
            mgr_addr_q  <= sbr_addr_i;
            atop_q      <= sbr_atop_i;
            operand_q   <= sbr_wdata_i;
            is_amo_q    <= is_amo;
            case (path)
              PATH_READ: begin
                state_q     <= RD_REQ;
                mgr_req_q   <= 1'b1;
                mgr_we_q    <= 1'b0;
                mgr_be_q    <= 4'hF;
                mgr_wdata_q <= '0;
              end
              PATH_WRITE: begin
                state_q     <= WR_REQ;
                mgr_req_q   <= 1'b1;
                mgr_we_q    <= 1'b1;
                mgr_be_q    <= sbr_be_i;
                mgr_wdata_q <= sbr_wdata_i;
              end
              PATH_SC_FAIL: begin
                state_q      <= RESP;
                sbr_rvalid_q <= 1'b1;
                sbr_rdata_q  <= 32'd1;
              end
              default: begin
                state_q      <= RESP;
                sbr_rvalid_q <= 1'b1;
                sbr_err_q    <= 1'b1;
              end
            endcase
          end
        end
        RD_REQ: begin
          if (mgr_gnt_i) begin
            state_q   <= RD_WAIT;
            mgr_req_q <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mgr_rvalid_i) begin
            old_q <= mgr_rdata_i;
            // A failed AMO read must not be followed by a write of a bogus value.
            if (is_amo_q && !mgr_err_i) begin
              state_q     <= WR_REQ;
              mgr_req_q   <= 1'b1;
              mgr_we_q    <= 1'b1;
              mgr_be_q    <= 4'hF;
              mgr_wdata_q <= amo_calc(atop_q, mgr_rdata_i, operand_q);
            end else begin
              state_q      <= RESP;
              sbr_rvalid_q <= 1'b1;
              sbr_rdata_q  <= mgr_rdata_i;
              sbr_err_q    <= mgr_err_i;
            end
          end
        end
        WR_REQ: begin
          if (mgr_gnt_i) begin
            state_q   <= WR_WAIT;
            mgr_req_q <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (mgr_rvalid_i) begin
            state_q      <= RESP;
            sbr_rvalid_q <= 1'b1;
            sbr_rdata_q  <= is_amo_q ? old_q : 32'd0;
            sbr_err_q    <= mgr_err_i;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          sbr_gnt_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          sbr_gnt_q <= 1'b1;
          mgr_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are held at zero for as long as reset is asserted, not just after the first edge.
  assign sbr_gnt_o    = rst_ni & sbr_gnt_q;
  assign sbr_rvalid_o = rst_ni & sbr_rvalid_q;
  assign sbr_err_o    = rst_ni & sbr_err_q;
  assign sbr_rdata_o  = rst_ni ? sbr_rdata_q : '0;
  assign sbr_rid_o    = rst_ni ? sbr_rid_q : '0;
  assign mgr_req_o    = rst_ni & mgr_req_q;
  assign mgr_we_o     = rst_ni & mgr_we_q;
  assign mgr_be_o     = rst_ni ? mgr_be_q : '0;
  assign mgr_addr_o   = rst_ni ? mgr_addr_q : '0;
  assign mgr_wdata_o  = rst_ni ? mgr_wdata_q : '0;

endmodule

// File: tb/tb_obi_atop_resolver.sv
// Directed bench for obi_atop_resolver with a word-addressed memory on the manager port.
// LR/SC steps follow OBI_ATOP_RESOLVER_LRSC_EN.
module tb_obi_atop_resolver;

  localparam logic [5:0] NONE = 6'h00, ADD = 6'h20, SWAP = 6'h21, LR = 6'h22, SC = 6'h23;
  localparam logic [5:0] OR_ = 6'h28, MAX = 6'h34, MAXU = 6'h3C, BAD = 6'h3F;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        sbr_req_i, sbr_gnt_o, sbr_we_i, sbr_rvalid_o, sbr_err_o;
  logic [31:0] sbr_addr_i, sbr_wdata_i, sbr_rdata_o;
  logic [3:0]  sbr_be_i;
  logic [0:0]  sbr_aid_i, sbr_rid_o;
  logic [5:0]  sbr_atop_i;
  logic        mgr_req_o, mgr_gnt_i, mgr_we_o, mgr_rvalid_i, mgr_err_i;
  logic [31:0] mgr_addr_o, mgr_wdata_o, mgr_rdata_i;
  logic [3:0]  mgr_be_o;

  logic [31:0] mem [0:255];
  int          req_cnt = 0;
  logic        inject_err;
  int          errors = 0;
  int          checks = 0;

  obi_atop_resolver #(.AddrWidth(32), .IdWidth(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .sbr_req_i(sbr_req_i), .sbr_gnt_o(sbr_gnt_o), .sbr_addr_i(sbr_addr_i),
    .sbr_we_i(sbr_we_i), .sbr_be_i(sbr_be_i), .sbr_wdata_i(sbr_wdata_i),
    .sbr_aid_i(sbr_aid_i), .sbr_atop_i(sbr_atop_i), .sbr_rvalid_o(sbr_rvalid_o),
    .sbr_rdata_o(sbr_rdata_o), .sbr_rid_o(sbr_rid_o), .sbr_err_o(sbr_err_o),
    .mgr_req_o(mgr_req_o), .mgr_gnt_i(mgr_gnt_i), .mgr_addr_o(mgr_addr_o),
    .mgr_we_o(mgr_we_o), .mgr_be_o(mgr_be_o), .mgr_wdata_o(mgr_wdata_o),
    .mgr_rvalid_i(mgr_rvalid_i), .mgr_rdata_i(mgr_rdata_i), .mgr_err_i(mgr_err_i)
  );

  always #5 clk = ~clk;

  // Memory: grant always, response one cycle after the granted request.
  always @(posedge clk) begin
    mgr_rvalid_i <= 1'b0;
    mgr_err_i    <= 1'b0;
    if (mgr_req_o && mgr_gnt_i) begin
      mgr_rvalid_i <= 1'b1;
      mgr_err_i    <= inject_err;
      mgr_rdata_i  <= mem[mgr_addr_o[9:2]];
      req_cnt      <= req_cnt + 1;
      if (mgr_we_o && !inject_err)
        for (int b = 0; b < 4; b++)
          if (mgr_be_o[b]) mem[mgr_addr_o[9:2]][8*b +: 8] <= mgr_wdata_o[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [5:0] atop, input logic we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic id,
                     output logic [31:0] rdata, output logic err, output logic rid,
                     output int lat);
    int n;
    @(negedge clk);
    sbr_req_i = 1'b1; sbr_atop_i = atop; sbr_we_i = we; sbr_be_i = be;
    sbr_addr_i = addr; sbr_wdata_i = wdata; sbr_aid_i = id;
    n = 0;
    while (!sbr_gnt_o && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    sbr_req_i = 1'b0;
    lat = 1;
    while (!sbr_rvalid_o && lat < 30) begin @(negedge clk); lat++; end
    if (!sbr_rvalid_o) lat = -1;
    rdata = sbr_rdata_o; err = sbr_err_o; rid = sbr_rid_o;
    $display("txn atop=%h we=%b be=%h addr=%h wdata=%h -> rdata=%h err=%b rid=%b lat=%0d",
             atop, we, be, addr, wdata, rdata, err, rid, lat);
  endtask

  logic [31:0] rd;
  logic        er, ri, seen;
  int          lt, base;

  initial begin
    rst_ni = 1'b0; inject_err = 1'b0; mgr_gnt_i = 1'b1;
    sbr_req_i = 1'b0; sbr_atop_i = '0; sbr_we_i = 1'b0; sbr_be_i = '0;
    sbr_addr_i = '0; sbr_wdata_i = '0; sbr_aid_i = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", {31'd0, sbr_gnt_o}, 32'd0);
    check("rst_rvalid", {31'd0, sbr_rvalid_o}, 32'd0);
    check("rst_mgr_req", {31'd0, mgr_req_o}, 32'd0);
    check("rst_rdata", sbr_rdata_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("gnt_after_rst", {31'd0, sbr_gnt_o}, 32'd1);

    // Plain write then read back.
    txn(NONE, 1'b1, 4'hF, 32'h100, 32'h1234_5678, 1'b1, rd, er, ri, lt);
    check("wr_rdata", rd, 32'd0); check("wr_err", {31'd0, er}, 32'd0);
    check("wr_rid", {31'd0, ri}, 32'd1); check("wr_lat", lt, 32'd3);
    check("wr_mem", mem[64], 32'h1234_5678);
    txn(NONE, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, rd, er, ri, lt);
    check("rd_rdata", rd, 32'h1234_5678); check("rd_err", {31'd0, er}, 32'd0);
    check("rd_rid", {31'd0, ri}, 32'd0); check("rd_lat", lt, 32'd3);
    @(negedge clk);
    check("rvalid_one_cycle", {31'd0, sbr_rvalid_o}, 32'd0);

    // AMOADD wraps around.
    txn(NONE, 1'b1, 4'hF, 32'h40, 32'hFFFF_FFFF, 1'b0, rd, er, ri, lt);
    txn(ADD, 1'b1, 4'hF, 32'h40, 32'd2, 1'b1, rd, er, ri, lt);
    check("add_rdata", rd, 32'hFFFF_FFFF); check("add_lat", lt, 32'd5);
    check("add_rid", {31'd0, ri}, 32'd1); check("add_mem", mem[16], 32'h0000_0001);
    txn(NONE, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, rd, er, ri, lt);
    check("add_readback", rd, 32'h0000_0001);

    // Signed versus unsigned max.
    txn(NONE, 1'b1, 4'hF, 32'h44, 32'h8000_0000, 1'b0, rd, er, ri, lt);
    txn(MAX, 1'b1, 4'hF, 32'h44, 32'd1, 1'b0, rd, er, ri, lt);
    check("max_rdata", rd, 32'h8000_0000); check("max_mem", mem[17], 32'd1);
    txn(NONE, 1'b1, 4'hF, 32'h44, 32'h8000_0000, 1'b0, rd, er, ri, lt);
    txn(MAXU, 1'b1, 4'hF, 32'h44, 32'd1, 1'b0, rd, er, ri, lt);
    check("maxu_rdata", rd, 32'h8000_0000); check("maxu_mem", mem[17], 32'h8000_0000);

    // Partial-byte AMO and unknown code are rejected without memory access.
    base = req_cnt;
    txn(OR_, 1'b1, 4'h3, 32'h40, 32'hF0, 1'b0, rd, er, ri, lt);
    check("amo_be_err", {31'd0, er}, 32'd1); check("amo_be_rdata", rd, 32'd0);
    check("amo_be_lat", lt, 32'd1);
    txn(BAD, 1'b0, 4'hF, 32'h40, 32'h0, 1'b1, rd, er, ri, lt);
    check("bad_err", {31'd0, er}, 32'd1); check("bad_rid", {31'd0, ri}, 32'd1);
    check("reject_no_mgr", req_cnt - base, 32'd0);
    check("amo_be_mem", mem[16], 32'd1);

    // Error on the AMO read aborts the write.
    inject_err = 1'b1;
    base = req_cnt;
    txn(SWAP, 1'b1, 4'hF, 32'h40, 32'hDEAD, 1'b0, rd, er, ri, lt);
    inject_err = 1'b0;
    check("amo_rderr_err", {31'd0, er}, 32'd1); check("amo_rderr_accesses", req_cnt - base, 32'd1);
    check("amo_rderr_mem", mem[16], 32'd1); check("amo_rderr_lat", lt, 32'd3);

`ifdef OBI_ATOP_RESOLVER_LRSC_EN
    txn(NONE, 1'b1, 4'hF, 32'h80, 32'h55, 1'b0, rd, er, ri, lt);
    txn(LR, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0, rd, er, ri, lt);
    check("lr_rdata", rd, 32'h55); check("lr_lat", lt, 32'd3);
    txn(SC, 1'b1, 4'hF, 32'h80, 32'd7, 1'b0, rd, er, ri, lt);
    check("sc_ok_rdata", rd, 32'd0); check("sc_ok_err", {31'd0, er}, 32'd0);
    check("sc_ok_mem", mem[32], 32'd7);
    txn(SC, 1'b1, 4'hF, 32'h80, 32'd9, 1'b0, rd, er, ri, lt);
    check("sc_again_rdata", rd, 32'd1); check("sc_again_mem", mem[32], 32'd7);
    check("sc_again_lat", lt, 32'd1);
    txn(LR, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0, rd, er, ri, lt);
    txn(NONE, 1'b1, 4'hF, 32'h80, 32'h11, 1'b0, rd, er, ri, lt);
    txn(SC, 1'b1, 4'hF, 32'h80, 32'd5, 1'b0, rd, er, ri, lt);
    check("sc_broken_rdata", rd, 32'd1); check("sc_broken_mem", mem[32], 32'h11);
`else
    base = req_cnt;
    txn(LR, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0, rd, er, ri, lt);
    check("lr_disabled_err", {31'd0, er}, 32'd1);
    txn(SC, 1'b1, 4'hF, 32'h80, 32'd7, 1'b0, rd, er, ri, lt);
    check("sc_disabled_err", {31'd0, er}, 32'd1); check("sc_disabled_rdata", rd, 32'd0);
    check("lrsc_disabled_no_mgr", req_cnt - base, 32'd0);
`endif

    // Reset while the read is waiting for its response.
    @(negedge clk);
    sbr_req_i = 1'b1; sbr_atop_i = NONE; sbr_we_i = 1'b0; sbr_be_i = 4'hF;
    sbr_addr_i = 32'h100; sbr_aid_i = 1'b1;
    @(negedge clk);
    sbr_req_i = 1'b0;
    @(negedge clk);
    check("mid_rd_wait_req", {31'd0, mgr_req_o}, 32'd0);
    rst_ni = 1'b0;
    @(negedge clk);
    check("midrst_gnt", {31'd0, sbr_gnt_o}, 32'd0);
    check("midrst_addr", mgr_addr_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("midrst_idle_gnt", {31'd0, sbr_gnt_o}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (sbr_rvalid_o) seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_resp", {31'd0, seen}, 32'd0);
    txn(NONE, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, rd, er, ri, lt);
    check("post_rst_rdata", rd, 32'h1234_5678); check("post_rst_lat", lt, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
